// File: rtl/ibex_pkg.sv
// Slice of the core package: multiplier/divider operator type and the RV32M
// funct3 decode used by the multdiv issue front-end.
package ibex_pkg;

  typedef enum logic [1:0] {
    MD_OP_MULL,
    MD_OP_MULH,
    MD_OP_DIV,
    MD_OP_REM
  } md_op_e;

  typedef struct packed {
    md_op_e     op;
    logic [1:0] signed_mode;  // [0] a signed, [1] b signed
    logic       is_mult;
  } md_decode_t;

  function automatic md_decode_t md_decode(input logic [2:0] funct3);
    md_decode_t d;
    d = '{op: MD_OP_MULL, signed_mode: 2'b00, is_mult: 1'b1};
    case (funct3)
      3'b000: d = '{op: MD_OP_MULL, signed_mode: 2'b00, is_mult: 1'b1};
      3'b001: d = '{op: MD_OP_MULH, signed_mode: 2'b11, is_mult: 1'b1};
      3'b010: d = '{op: MD_OP_MULH, signed_mode: 2'b01, is_mult: 1'b1};
      3'b011: d = '{op: MD_OP_MULH, signed_mode: 2'b00, is_mult: 1'b1};
      3'b100: d = '{op: MD_OP_DIV,  signed_mode: 2'b11, is_mult: 1'b0};
      3'b101: d = '{op: MD_OP_DIV,  signed_mode: 2'b00, is_mult: 1'b0};
      3'b110: d = '{op: MD_OP_REM,  signed_mode: 2'b11, is_mult: 1'b0};
      3'b111: d = '{op: MD_OP_REM,  signed_mode: 2'b00, is_mult: 1'b0};
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ibex_multdiv_issue_if.sv
// Request/response channels of the multdiv issue front-end.
// master = the ID stage side, slave = the issue block.
interface ibex_multdiv_issue_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_op_a;
  logic [31:0] req_op_b;
  logic [4:0]  req_tag;
  logic        flush;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [4:0]  rsp_tag;
  logic [5:0]  rsp_cycles;

  modport master (
    output req_valid, req_funct3, req_op_a, req_op_b, req_tag, flush, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_tag, rsp_cycles
  );

  modport slave (
    input  req_valid, req_funct3, req_op_a, req_op_b, req_tag, flush, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_tag, rsp_cycles
  );
endinterface

// File: rtl/ibex_multdiv_issue.sv
// Issue/response front-end for the iterative multdiv unit: holds operands for the
// whole operation, drives the unit controls and buffers one result.
module ibex_multdiv_issue
  import ibex_pkg::*;
#(
  parameter bit DataIndTiming = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  ibex_multdiv_issue_if.slave bus,

  output logic                md_mult_en_o,
  output logic                md_mult_sel_o,
  output logic                md_div_en_o,
  output logic                md_div_sel_o,
  output md_op_e              md_operator_o,
  output logic [1:0]          md_signed_mode_o,
  output logic [31:0]         md_op_a_o,
  output logic [31:0]         md_op_b_o,
  output logic                md_data_ind_timing_o,
  output logic                md_ready_id_o,
  input  logic                md_valid_i,
  input  logic [31:0]         md_result_i
);

  typedef enum logic [1:0] {
    MDI_IDLE,
    MDI_BUSY,
    MDI_DRAIN,
    MDI_RESP
  } mdi_state_e;

  mdi_state_e  state_q, state_d;
  md_decode_t  dec;
  logic        accept, capture, active;
  logic        is_mult_q;
  logic [31:0] op_a_q, op_b_q;
  md_op_e      operator_q;
  logic [1:0]  signed_mode_q;
  logic [4:0]  tag_q;
  logic [5:0]  cnt_q, cnt_inc;
  logic [31:0] rsp_result_q;
  logic [4:0]  rsp_tag_q;
  logic [5:0]  rsp_cycles_q;

  assign dec     = md_decode(bus.req_funct3);
  assign accept  = bus.req_valid & bus.req_ready;
  assign capture = (state_q == MDI_BUSY) & md_valid_i & ~bus.flush;
  assign cnt_inc = (cnt_q == 6'd63) ? cnt_q : cnt_q + 6'd1;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= MDI_IDLE;
    else       state_q <= state_d;
  end

  // DRAIN keeps the unit running after a flush so it never stops mid-iteration.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MDI_IDLE:  if (accept) state_d = MDI_BUSY;
      MDI_BUSY: begin
        if (md_valid_i)     state_d = bus.flush ? MDI_IDLE : MDI_RESP;
        else if (bus.flush) state_d = MDI_DRAIN;
      end
      MDI_DRAIN: if (md_valid_i) state_d = MDI_IDLE;
      MDI_RESP: begin
        if (bus.flush)          state_d = MDI_IDLE;
        else if (bus.rsp_ready) state_d = accept ? MDI_BUSY : MDI_IDLE;
      end
      default: state_d = MDI_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    active        = 1'b0;
    case (state_q)
      MDI_IDLE:  bus.req_ready = ~bus.flush;
      MDI_BUSY,
      MDI_DRAIN: active = 1'b1;
      MDI_RESP: begin
        bus.rsp_valid = 1'b1;
        bus.req_ready = bus.rsp_ready & ~bus.flush;
      end
      default: ;
    endcase
  end

  assign md_mult_en_o         = active & is_mult_q;
  assign md_mult_sel_o        = active & is_mult_q;
  assign md_div_en_o          = active & ~is_mult_q;
  assign md_div_sel_o         = active & ~is_mult_q;
  assign md_ready_id_o        = active;
  assign md_operator_o        = operator_q;
  assign md_signed_mode_o     = signed_mode_q;
  assign md_op_a_o            = op_a_q;
  assign md_op_b_o            = op_b_q;
  assign md_data_ind_timing_o = DataIndTiming;

  // Accepts only happen in IDLE/RESP, where the unit is idle, so the held
  // operands never change under a running operation.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_a_q        <= '0;
      op_b_q        <= '0;
      tag_q         <= '0;
      operator_q    <= MD_OP_MULL;
      signed_mode_q <= '0;
      is_mult_q     <= 1'b0;
      cnt_q         <= '0;
      rsp_result_q  <= '0;
      rsp_tag_q     <= '0;
      rsp_cycles_q  <= '0;
    end else begin
      if (accept) begin
        op_a_q        <= bus.req_op_a;
        op_b_q        <= bus.req_op_b;
        tag_q         <= bus.req_tag;
        operator_q    <= dec.op;
        signed_mode_q <= dec.signed_mode;
        is_mult_q     <= dec.is_mult;
        cnt_q         <= '0;
      end else if (state_q == MDI_BUSY) begin
        cnt_q <= cnt_inc;
      end
      if (capture) begin
        rsp_result_q <= md_result_i;
        rsp_tag_q    <= tag_q;
        rsp_cycles_q <= cnt_inc;
      end
    end
  end

  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_tag    = rsp_tag_q;
  assign bus.rsp_cycles = rsp_cycles_q;

endmodule

// File: tb/tb_ibex_multdiv_issue.sv
// Bench: two issue blocks (non-DIT and DIT), each paired with a cycle-level
// stand-in for ibex_multdiv_slow plus its ALU adder; one is driven at a time.
module tb_ibex_multdiv_issue;
  import ibex_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  logic        sel;
  logic        req_valid, flush, rsp_ready;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic [4:0]  tag;

  logic [1:0]        req_ready_v, rsp_valid_v, ready_id_v, md_valid_v;
  logic [1:0][3:0]   ctrl_v;
  logic [1:0][31:0]  rsp_result_v, md_a_v, md_b_v;
  logic [1:0][4:0]   rsp_tag_v;
  logic [1:0][5:0]   rsp_cycles_v;
  logic [1:0][15:0]  errs_v;

  logic        req_ready, rsp_valid, ready_id, md_valid;
  logic [3:0]  ctrl;
  logic [31:0] rsp_result, md_a, md_b;
  logic [4:0]  rsp_tag;
  logic [5:0]  rsp_cycles;

  assign req_ready  = req_ready_v[sel];
  assign rsp_valid  = rsp_valid_v[sel];
  assign ready_id   = ready_id_v[sel];
  assign md_valid   = md_valid_v[sel];
  assign ctrl       = ctrl_v[sel];
  assign rsp_result = rsp_result_v[sel];
  assign md_a       = md_a_v[sel];
  assign md_b       = md_b_v[sel];
  assign rsp_tag    = rsp_tag_v[sel];
  assign rsp_cycles = rsp_cycles_v[sel];

  function automatic logic [31:0] unit_result(input md_op_e op, input logic [1:0] sm,
                                              input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ax, bx, p;
    logic signed [31:0] sa, sb;
    logic ovf;
    ax  = {{32{sm[0] & a[31]}}, a};
    bx  = {{32{sm[1] & b[31]}}, b};
    p   = ax * bx;
    sa  = a;
    sb  = b;
    ovf = (sm == 2'b11) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      MD_OP_MULL: return p[31:0];
      MD_OP_MULH: return p[63:32];
      MD_OP_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        if (sm == 2'b11) return sa / sb;
        return a / b;
      end
      default: begin
        if (b == 32'd0) return a;
        if (ovf) return 32'd0;
        if (sm == 2'b11) return sa % sb;
        return a % b;
      end
    endcase
  endfunction

  function automatic int unit_latency(input md_op_e op, input logic dit, input logic [31:0] b);
    if (op == MD_OP_MULL || op == MD_OP_MULH)
      return (!dit && op == MD_OP_MULL && b <= 32'd1) ? 2 : 33;
    return (!dit && b == 32'd0) ? 2 : 37;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : u
    ibex_multdiv_issue_if bif ();
    logic        mult_en, mult_sel, div_en, div_sel, dit, rdy_id, mvalid, mine;
    md_op_e      oper;
    logic [1:0]  smode;
    logic [31:0] ma, mb, mres;
    int          ucnt = 0;
    int          errs = 0;

    assign mine           = (sel == (g == 1));
    assign bif.req_valid  = req_valid & mine;
    assign bif.req_funct3 = funct3;
    assign bif.req_op_a   = op_a;
    assign bif.req_op_b   = op_b;
    assign bif.req_tag    = tag;
    assign bif.flush      = flush & mine;
    assign bif.rsp_ready  = rsp_ready & mine;

    ibex_multdiv_issue #(.DataIndTiming(g == 1)) dut (
      .clk_i               (clk_i),
      .rst_i               (rst_i),
      .bus                 (bif),
      .md_mult_en_o        (mult_en),
      .md_mult_sel_o       (mult_sel),
      .md_div_en_o         (div_en),
      .md_div_sel_o        (div_sel),
      .md_operator_o       (oper),
      .md_signed_mode_o    (smode),
      .md_op_a_o           (ma),
      .md_op_b_o           (mb),
      .md_data_ind_timing_o(dit),
      .md_ready_id_o       (rdy_id),
      .md_valid_i          (mvalid),
      .md_result_i         (mres)
    );

    // Unit stand-in: counts enabled cycles and pulses valid in the last one.
    assign mvalid = (mult_en | div_en) && (ucnt + 1 == unit_latency(oper, dit, mb));
    assign mres   = mvalid ? unit_result(oper, smode, ma, mb) : 32'hDEAD_BEEF;

    always @(posedge clk_i) begin
      if (!rst_i && ucnt != 0 && !(mult_en | div_en)) errs <= errs + 1;
      if (!rst_i && (mult_en != mult_sel || div_en != div_sel || (mult_en && div_en)))
        errs <= errs + 1;
      if (rst_i) ucnt <= 0;
      else if (mult_en | div_en) ucnt <= mvalid ? 0 : ucnt + 1;
    end

    assign req_ready_v[g]  = bif.req_ready;
    assign rsp_valid_v[g]  = bif.rsp_valid;
    assign rsp_result_v[g] = bif.rsp_result;
    assign rsp_tag_v[g]    = bif.rsp_tag;
    assign rsp_cycles_v[g] = bif.rsp_cycles;
    assign ready_id_v[g]   = rdy_id;
    assign md_valid_v[g]   = mvalid;
    assign ctrl_v[g]       = {mult_en, mult_sel, div_en, div_sel};
    assign md_a_v[g]       = ma;
    assign md_b_v[g]       = mb;
    assign errs_v[g]       = 16'(errs);
  end

  // Drive a request from a negedge until accepted; returns at the negedge of cycle 1.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t, output bit ok);
    req_valid = 1'b1; funct3 = f3; op_a = a; op_b = b; tag = t;
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      #1;
      if (req_ready) ok = 1'b1;
      @(negedge clk_i);
    end
    req_valid = 1'b0;
  endtask

  // k = cycle (1 = first after accept) in which rsp_valid is first seen.
  task automatic wait_rsp(output int k, output bit seen);
    k = 1; seen = 1'b0;
    while (!seen && k < 200) begin
      #1;
      if (rsp_valid) seen = 1'b1;
      else begin @(negedge clk_i); k++; end
    end
  endtask

  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t, output bit seen, output int k,
                       output logic [31:0] res, output logic [4:0] tg, output logic [5:0] cy);
    bit ok;
    issue(f3, a, b, t, ok);
    wait_rsp(k, seen);
    res = rsp_result; tg = rsp_tag; cy = rsp_cycles;
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
    total++; if ({rsp_result, rsp_tag, rsp_cycles} !== 43'd0) begin bad++; $display("FAIL reset_rsp got=%h/%h/%h want=0", rsp_result, rsp_tag, rsp_cycles); end
    total++; if ({ctrl, ready_id} !== 5'd0) begin bad++; $display("FAIL reset_ctrl got=%b want=00000", {ctrl, ready_id}); end
    total++; if ({md_a, md_b} !== 64'd0) begin bad++; $display("FAIL reset_operands got=%h want=0", {md_a, md_b}); end
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_div();
    logic [2:0]  f3s [2] = '{3'b100, 3'b110};
    logic [31:0] er  [2] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF};
    bit seen; int k; logic [31:0] res; logic [4:0] tg; logic [5:0] cy;
    for (int i = 0; i < 2; i++) begin
      do_op(f3s[i], 32'hFFFF_FFF9, 32'h2, 5'(11 + i), seen, k, res, tg, cy);
      total++; if (!seen || res !== er[i]) begin bad++; $display("FAIL div[%0d]_result seen=%b got=%h want=%h", i, seen, res, er[i]); end
      total++; if (tg !== 5'(11 + i)) begin bad++; $display("FAIL div[%0d]_tag got=%0d want=%0d", i, tg, 11 + i); end
      total++; if (cy !== 6'd37 || k != 38) begin bad++; $display("FAIL div[%0d]_cycles got=%0d latency=%0d want=37/38", i, cy, k); end
    end
  endtask

  task automatic test_div_zero();
    logic        sels [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [2:0]  f3s  [4] = '{3'b101, 3'b110, 3'b101, 3'b110};
    logic [31:0] er   [4] = '{32'hFFFF_FFFF, 32'h5, 32'hFFFF_FFFF, 32'h5};
    int          ec   [4] = '{2, 2, 37, 37};
    bit seen; int k; logic [31:0] res; logic [4:0] tg; logic [5:0] cy;
    for (int i = 0; i < 4; i++) begin
      sel = sels[i];
      do_op(f3s[i], 32'd5, 32'd0, 5'd20, seen, k, res, tg, cy);
      total++; if (!seen || res !== er[i]) begin bad++; $display("FAIL divzero[%0d]_result seen=%b got=%h want=%h", i, seen, res, er[i]); end
      total++; if (cy !== 6'(ec[i]) || k != ec[i] + 1) begin bad++; $display("FAIL divzero[%0d]_cycles got=%0d latency=%0d want=%0d", i, cy, k, ec[i]); end
    end
    sel = 1'b0;
  endtask

  task automatic test_mult();
    logic [2:0]  f3s [3] = '{3'b001, 3'b010, 3'b000};
    logic [31:0] as  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd7};
    logic [31:0] bs  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd1};
    logic [31:0] er  [3] = '{32'h4000_0000, 32'hFFFF_FFFF, 32'd7};
    int          ec  [3] = '{33, 33, 2};
    bit seen; int k; logic [31:0] res; logic [4:0] tg; logic [5:0] cy;
    for (int i = 0; i < 3; i++) begin
      do_op(f3s[i], as[i], bs[i], 5'(i + 1), seen, k, res, tg, cy);
      total++; if (!seen || res !== er[i]) begin bad++; $display("FAIL mult[%0d]_result seen=%b got=%h want=%h", i, seen, res, er[i]); end
      total++; if (cy !== 6'(ec[i]) || k != ec[i] + 1 || tg !== 5'(i + 1)) begin bad++; $display("FAIL mult[%0d]_cycles got=%0d latency=%0d tag=%0d want=%0d tag %0d", i, cy, k, tg, ec[i], i + 1); end
    end
  endtask

  task automatic test_flush_busy();
    bit ok, any_rsp, seen; int k, rr_k; logic [31:0] res; logic [4:0] tg; logic [5:0] cy;
    issue(3'b100, 32'hFFFF_FFF9, 32'h2, 5'd3, ok);
    k = 1; rr_k = 0; any_rsp = 1'b0;
    while (k < 80 && rr_k == 0) begin
      flush = (k == 10 || k == 20);
      #1;
      if (rsp_valid) any_rsp = 1'b1;
      if (req_ready) rr_k = k;
      @(negedge clk_i); k++;
    end
    flush = 1'b0;
    total++; if (any_rsp) begin bad++; $display("FAIL flush_busy_rsp got=1 want=0"); end
    total++; if (rr_k != 38) begin bad++; $display("FAIL flush_busy_ready_cycle got=%0d want=38", rr_k); end
    flush = 1'b1; #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL idle_flush_ready got=%b want=0", req_ready); end
    flush = 1'b0;
    @(negedge clk_i);
    do_op(3'b101, 32'd100, 32'd7, 5'd4, seen, k, res, tg, cy);
    total++; if (!seen || res !== 32'd14 || tg !== 5'd4) begin bad++; $display("FAIL after_flush_divu got=%h tag=%0d want=0000000e tag 4", res, tg); end
    total++; if (cy !== 6'd37 || k != 38) begin bad++; $display("FAIL after_flush_cycles got=%0d latency=%0d want=37/38", cy, k); end
  endtask

  task automatic test_flush_valid();
    bit ok, any_rsp;
    issue(3'b100, 32'hFFFF_FFF9, 32'h2, 5'd6, ok);
    repeat (36) @(negedge clk_i);
    flush = 1'b1; #1;
    total++; if (md_valid !== 1'b1) begin bad++; $display("FAIL flush_valid_align got=%b want=1", md_valid); end
    @(negedge clk_i); flush = 1'b0; #1;
    total++; if ({rsp_valid, req_ready} !== 2'b01) begin bad++; $display("FAIL flush_valid_idle got=%b want=01", {rsp_valid, req_ready}); end
    any_rsp = 1'b0;
    repeat (3) begin @(negedge clk_i); #1; if (rsp_valid) any_rsp = 1'b1; end
    total++; if (any_rsp) begin bad++; $display("FAIL flush_valid_rsp got=1 want=0"); end
    @(negedge clk_i);
  endtask

  task automatic test_backpressure();
    bit ok, seen; int k;
    rsp_ready = 1'b0;
    issue(3'b000, 32'd7, 32'd1, 5'd9, ok);
    wait_rsp(k, seen);
    total++; if (!seen || k != 3) begin bad++; $display("FAIL bp_first_rsp seen=%b latency=%0d want=1/3", seen, k); end
    funct3 = 3'b011; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; tag = 5'd10; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i); #1;
      total++; if ({rsp_valid, rsp_result, rsp_tag, req_ready} !== {1'b1, 32'd7, 5'd9, 1'b0}) begin bad++; $display("FAIL bp_hold[%0d] got=%b/%h/%0d/%b want=1/00000007/9/0", i, rsp_valid, rsp_result, rsp_tag, req_ready); end
    end
    @(negedge clk_i); rsp_ready = 1'b1; #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_pop_accept got=%b want=1", req_ready); end
    @(negedge clk_i); req_valid = 1'b0; rsp_ready = 1'b0; #1;
    total++; if ({rsp_valid, ctrl, ready_id} !== 6'b011001) begin bad++; $display("FAIL bp_busy_after_pop got=%b want=011001", {rsp_valid, ctrl, ready_id}); end
    wait_rsp(k, seen);
    total++; if (!seen || rsp_result !== 32'hFFFF_FFFE || rsp_tag !== 5'd10) begin bad++; $display("FAIL bp_mulhu got=%h tag=%0d want=fffffffe tag 10", rsp_result, rsp_tag); end
    total++; if (rsp_cycles !== 6'd33 || k != 34) begin bad++; $display("FAIL bp_mulhu_cycles got=%0d latency=%0d want=33/34", rsp_cycles, k); end
    @(negedge clk_i); flush = 1'b1; rsp_ready = 1'b1; #1;
    total++; if ({rsp_valid, req_ready} !== 2'b10) begin bad++; $display("FAIL resp_flush_ready got=%b want=10", {rsp_valid, req_ready}); end
    @(negedge clk_i); flush = 1'b0; #1;
    total++; if ({rsp_valid, req_ready} !== 2'b01) begin bad++; $display("FAIL resp_flush_drop got=%b want=01", {rsp_valid, req_ready}); end
    @(negedge clk_i);
  endtask

  task automatic test_reset_mid();
    bit ok, seen; int k; logic [31:0] res; logic [4:0] tg; logic [5:0] cy;
    issue(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd12, ok);
    repeat (9) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i); #1;
    total++; if ({rsp_valid, rsp_result, rsp_tag, rsp_cycles} !== 44'd0) begin bad++; $display("FAIL midreset_rsp got=%b/%h/%0d/%0d want=0", rsp_valid, rsp_result, rsp_tag, rsp_cycles); end
    total++; if ({ctrl, ready_id, md_a, md_b} !== 69'd0) begin bad++; $display("FAIL midreset_unit got=%b/%h/%h want=0", {ctrl, ready_id}, md_a, md_b); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL midreset_ready got=%b want=1", req_ready); end
    rst_i = 1'b0;
    @(negedge clk_i);
    do_op(3'b000, 32'd3, 32'd5, 5'd13, seen, k, res, tg, cy);
    total++; if (!seen || res !== 32'd15 || tg !== 5'd13 || cy !== 6'd33) begin bad++; $display("FAIL midreset_mul got=%h tag=%0d cyc=%0d want=0000000f tag 13 cyc 33", res, tg, cy); end
  endtask

  task automatic test_ctrl_monitor();
    total++; if (errs_v[0] !== 16'd0) begin bad++; $display("FAIL ctrl_drop_nondit got=%0d want=0", errs_v[0]); end
    total++; if (errs_v[1] !== 16'd0) begin bad++; $display("FAIL ctrl_drop_dit got=%0d want=0", errs_v[1]); end
  endtask

  initial begin
    sel = 1'b0; rst_i = 1'b1; req_valid = 1'b0; flush = 1'b0; rsp_ready = 1'b1;
    funct3 = '0; op_a = '0; op_b = '0; tag = '0;
    test_reset();
    test_div();
    test_div_zero();
    test_mult();
    test_flush_busy();
    test_flush_valid();
    test_backpressure();
    test_reset_mid();
    test_ctrl_monitor();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
